// File: rtl/fdiv_pkg.sv
// fdiv_pkg: shared constants for the float-divide result stage.
// Flag bit positions inside the 5-bit {invalid,dz,ovf,unf,zero} vector.
package fdiv_pkg;
    localparam int F_INV  = 4;
    localparam int F_DZ   = 3;
    localparam int F_OVF  = 2;
    localparam int F_UNF  = 1;
    localparam int F_ZERO = 0;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [7:0]  EXP_MAX = 8'hFF;
    localparam int          BIAS    = 127;
endpackage

// File: rtl/fdiv_classify.sv
// fdiv_classify: combinational IEEE-754 single special-case override of a divider quotient.
// Denormal operands are flushed to zero; only exponents matter for classification.
module fdiv_classify
    import fdiv_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] q,
    output logic [31:0] data,
    output logic [4:0]  flags
);
    logic za, zb, sa, sb, s;
    logic signed [9:0] e;
    logic unused_mant;
    assign za = a[30:23] == 8'h00;
    assign zb = b[30:23] == 8'h00;
    assign sa = a[30:23] == EXP_MAX;
    assign sb = b[30:23] == EXP_MAX;
    assign s  = a[31] ^ b[31];
    assign e  = $signed({2'b0, a[30:23]} - {2'b0, b[30:23]} + 10'(BIAS));
    assign unused_mant = ^{a[22:0], b[22:0]};
    always_comb begin
        data  = q;
        flags = '0;
        if (sa | sb | (za & zb)) begin
            data         = QNAN;
            flags[F_INV] = 1'b1;
        end else if (zb) begin
            data        = {s, EXP_MAX, 23'h0};
            flags[F_DZ] = 1'b1;
        end else if (za) begin
            data          = {s, 31'h0};
            flags[F_ZERO] = 1'b1;
        end else if (e > 10'sd254) begin
            data         = {s, EXP_MAX, 23'h0};
            flags[F_OVF] = 1'b1;
        end else if (e < 10'sd1) begin
            data          = {s, 31'h0};
            flags[F_UNF]  = 1'b1;
            flags[F_ZERO] = 1'b1;
        end
    end
endmodule

// File: rtl/fdiv_result_stage.sv
// fdiv_result_stage: registered divider writeback with special-case override and 2-entry skid buffer.
// Optional sticky flags / saturating op counter enabled by defining FDIV_STICKY_STATUS_EN.
module fdiv_result_stage
    import fdiv_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [31:0]      in_q,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [4:0]       out_flags,
    input  logic             status_clr,
    output logic [4:0]       sticky_flags,
    output logic [CNT_W-1:0] op_count
);
    logic [31:0] c_data, skid_data;
    logic [4:0]  c_flags, skid_flags;
    logic        main_valid, skid_valid, in_hs, out_hs;

    fdiv_classify u_cls (.a(in_a), .b(in_b), .q(in_q), .data(c_data), .flags(c_flags));

    assign out_valid = main_valid;
    assign in_ready  = ~skid_valid;
    assign in_hs     = in_valid & in_ready;
    assign out_hs    = main_valid & out_ready;

    // Skid only fills while main is stalled, and in_ready is low while it is full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            out_data   <= '0;
            out_flags  <= '0;
            skid_data  <= '0;
            skid_flags <= '0;
        end else if (~main_valid | out_hs) begin
            if (skid_valid) begin
                main_valid <= 1'b1;
                out_data   <= skid_data;
                out_flags  <= skid_flags;
                skid_valid <= 1'b0;
            end else begin
                main_valid <= in_hs;
                if (in_hs) begin
                    out_data  <= c_data;
                    out_flags <= c_flags;
                end
            end
        end else if (in_hs) begin
            skid_valid <= 1'b1;
            skid_data  <= c_data;
            skid_flags <= c_flags;
        end
    end

`ifdef FDIV_STICKY_STATUS_EN
    // Clear has priority over a coinciding handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_flags <= '0;
            op_count     <= '0;
        end else if (status_clr) begin
            sticky_flags <= '0;
            op_count     <= '0;
        end else if (out_hs) begin
            sticky_flags <= sticky_flags | out_flags;
            if (op_count != '1) op_count <= op_count + CNT_W'(1);
        end
    end
`else
    logic unused_clr;
    assign unused_clr   = status_clr;
    assign sticky_flags = '0;
    assign op_count     = '0;
`endif
endmodule
